// File: rtl/add_serial_param.sv
// Digit-serial add/subtract core: LSB digit first, result enters from the MSB end.
// Optional saturation on overflow when ADD_SERIAL_SAT_EN is defined.
module add_serial_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    count_q, count_d;

  logic [DIGIT:0]         dig_sum;
  logic [WIDTH+DIGIT-1:0] out_shift;
  logic                   ovf_now;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    dig_sum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    out_shift = {dig_sum[DIGIT-1:0], out_q};
    // Sign bits of A and B_eff sit in the top bit of the last digit.
    ovf_now   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dig_sum[DIGIT-1] != a_q[DIGIT-1]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          count_d = '0;
          out_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        out_d   = out_shift[WIDTH+DIGIT-1:DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_sum[DIGIT];
        count_d = count_q + CW'(1);
        if (count_q == CW'(NDIG - 1)) begin
          cout_d  = dig_sum[DIGIT];
          ovf_d   = ovf_now;
          state_d = ST_DONE;
`ifdef ADD_SERIAL_SAT_EN
          if (ovf_now) begin
            out_d = a_q[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_add_serial_param.sv
// Bench for add_serial_param: three configurations (8x1, 8x4, 16x1) checked against
// an arithmetic reference model with directed and random operands.
module tb_add_serial_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic        sub_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic [7:0]  out0, out1;
  logic [15:0] out2;
  logic [2:0]  cout_v, ovf_v, busy_v, done_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  add_serial_param #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .out(out0), .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  add_serial_param #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
    .out(out1), .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  add_serial_param #(.WIDTH(16), .DIGIT(1)) u_w16d1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_in), .a(a_in), .b(b_in),
    .out(out2), .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int idx);
    return (idx == 2) ? 16 : 8;
  endfunction

  function automatic int ndig(input int idx);
    return (idx == 0) ? 8 : (idx == 1) ? 2 : 16;
  endfunction

  function automatic longint get_out(input int idx);
    return (idx == 0) ? longint'(out0) : (idx == 1) ? longint'(out1) : longint'(out2);
  endfunction

  // Reference: plain two's-complement arithmetic on integers.
  task automatic model(input int w, input logic s, input longint av, input longint bv,
                       output longint eo, output logic ec, output logic ev);
    longint mask, am, bm, sum;
    logic   sa, sb, so;
    mask = (longint'(1) << w) - 1;
    am   = av & mask;
    bm   = bv & mask;
    sum  = s ? (am + ((~bm) & mask) + 1) : (am + bm);
    eo   = sum & mask;
    ec   = sum[w];
    sa   = am[w-1];
    sb   = bm[w-1];
    so   = eo[w-1];
    ev   = s ? ((sa != sb) && (so != sa)) : ((sa == sb) && (so != sa));
`ifdef ADD_SERIAL_SAT_EN
    if (ev) eo = sa ? (longint'(1) << (w-1)) : ((longint'(1) << (w-1)) - 1);
`endif
  endtask

  task automatic wait_done(input int idx, output int n);
    n = 0;
    while (!done_v[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input int idx, input string tag, input logic s,
                              input longint av, input longint bv);
    longint eo;
    logic   ec, ev;
    model(wid(idx), s, av, bv, eo, ec, ev);
    check($sformatf("%s_out[%0d]", tag, idx), get_out(idx), eo);
    check($sformatf("%s_cout[%0d]", tag, idx), cout_v[idx], ec);
    check($sformatf("%s_ovf[%0d]", tag, idx), ovf_v[idx], ev);
  endtask

  task automatic run_op(input int idx, input logic s, input logic [15:0] av, input logic [15:0] bv);
    int n, nb;
    @(negedge clk);
    sub_in = s; a_in = av; b_in = bv; start_v[idx] = 1'b1;
    @(negedge clk);
    start_v = '0;
    nb = busy_v[idx] ? 1 : 0;
    n  = 0;
    while (!done_v[idx] && n < 200) begin
      @(negedge clk);
      n++;
      if (busy_v[idx]) nb++;
    end
    check($sformatf("done_lat[%0d]", idx), n, ndig(idx));
    check($sformatf("busy_len[%0d]", idx), nb, ndig(idx) + 1);
    check_result(idx, "res", s, av, bv);
    @(negedge clk);
    check($sformatf("done_pulse[%0d]", idx), done_v[idx], 0);
    check($sformatf("idle[%0d]", idx), busy_v[idx], 0);
    check_result(idx, "hold", s, av, bv);
  endtask

  initial begin
    int n;
    #1;
    check("rst_out", out0, 0);
    check("rst_flags", {cout_v[0], ovf_v[0], busy_v[0], done_v[0]}, 0);
    #20 rst = 1'b0;

    run_op(0, 1'b0, 16'h3C, 16'h15);
    run_op(0, 1'b0, 16'hFF, 16'h01);
    run_op(0, 1'b0, 16'h7F, 16'h01);
    run_op(0, 1'b1, 16'h05, 16'h07);
    run_op(0, 1'b1, 16'h80, 16'h01);

    // Mid-operation start with different operands must be ignored.
    @(negedge clk);
    sub_in = 1'b0; a_in = 16'h3C; b_in = 16'h15; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    sub_in = 1'b1; a_in = 16'hFF; b_in = 16'hFF; start_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, n);
    check("ign_timeout", done_v[0], 1);
    check_result(0, "ign", 1'b0, 16'h3C, 16'h15);

    // Start held high across DONE: second op accepted only after an IDLE cycle.
    repeat (2) @(negedge clk);
    sub_in = 1'b0; a_in = 16'h12; b_in = 16'h34; start_v[0] = 1'b1;
    @(negedge clk);
    wait_done(0, n);
    check("b2b_timeout1", done_v[0], 1);
    check_result(0, "b2b1", 1'b0, 16'h12, 16'h34);
    a_in = 16'h40; b_in = 16'h0F;
    @(negedge clk);
    check("b2b_idle", busy_v[0], 0);
    @(negedge clk);
    check("b2b_accept", busy_v[0], 1);
    start_v[0] = 1'b0;
    wait_done(0, n);
    check("b2b_timeout2", done_v[0], 1);
    check_result(0, "b2b2", 1'b0, 16'h40, 16'h0F);

    // Asynchronous reset after three ADD cycles.
    @(negedge clk);
    sub_in = 1'b0; a_in = 16'h3C; b_in = 16'h15; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out", out0, 0);
    check("arst_flags", {cout_v[0], ovf_v[0], busy_v[0], done_v[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1'b0, 16'h01, 16'h02);

    run_op(1, 1'b0, 16'hA5, 16'h5B);
    run_op(2, 1'b0, 16'h7FFF, 16'h0001);
    run_op(2, 1'b1, 16'h8000, 16'h0001);

    for (int i = 0; i < 20; i++) begin
      run_op(i % 3, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
